// File: rtl/cache_types_pkg.sv
// Shared cache-side types and constants.
// Used by the line adaptor and the cache datapath.
package cache_types_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int OFFSET_BITS = 5;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W       = $clog2(BEATS);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: one 256-bit pmem transfer
// becomes a 4-beat 64-bit burst on the memory port.
module cacheline_adaptor
    import cache_types_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic                   pmem_resp,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,

    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam int               LOW_W     = LINE_WIDTH - BURST_WIDTH;

    adaptor_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [LINE_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                // Read has priority; a concurrent write stays pending.
                if (pmem_read) begin
                    addr_d  = pmem_address & ADDR_MASK;
                    cnt_d   = '0;
                    state_d = RD;
                end else if (pmem_write) begin
                    addr_d  = pmem_address & ADDR_MASK;
                    wbuf_d  = pmem_wdata;
                    cnt_d   = '0;
                    state_d = WR;
                end
            end
            RD: begin
                if (resp_i) begin
                    rbuf_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        // Separate assembly buffer keeps pmem_rdata
                        // stable until the next read completes.
                        rdata_d = {burst_i, rbuf_q[LOW_W-1:0]};
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_o     = (state_q == RD);
    assign write_o    = (state_q == WR);
    assign pmem_resp  = (state_q == DONE);
    assign pmem_rdata = rdata_q;
    assign address_o  = addr_q;
    assign burst_o    = wbuf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];

endmodule
